// File: rtl/fan_sample_sequencer.sv
// fan_sample_sequencer: clk_en prescaler, ADC req/ack sampling and strobe/config gating for FanCTRL
module fan_sample_sequencer #(
  parameter int ADC_BITWIDTH = 4,
  parameter int PRESCALE     = 10,
  parameter int SAMPLE_DIV   = 16,
  parameter int ACK_TIMEOUT  = 8
) (
  input  logic                    clk_i,
  input  logic                    rstn_i,
  input  logic                    enable_i,
  input  logic                    config_en_i,
  input  logic [ADC_BITWIDTH-1:0] adc_data_i,
  input  logic [ADC_BITWIDTH-1:0] set_value_i,
  input  logic                    adc_ack_i,
  output logic                    adc_req_o,
  output logic                    clk_en_o,
  output logic [ADC_BITWIDTH-1:0] ADC_value_o,
  output logic [ADC_BITWIDTH-1:0] SET_value_o,
  output logic                    dataVaild_STRB_o,
  output logic                    config_en_o,
  output logic                    timeout_o,
  output logic [1:0]              state_o
);
  localparam int PW = $clog2(PRESCALE);
  localparam int SW = $clog2(SAMPLE_DIV);
  localparam int TW = $clog2(ACK_TIMEOUT + 1);
  localparam logic [PW-1:0] P_LAST = PW'(PRESCALE - 1);
  localparam logic [SW-1:0] S_LAST = SW'(SAMPLE_DIV - 1);
  localparam logic [TW-1:0] T_LAST = TW'(ACK_TIMEOUT - 1);
  typedef enum logic [1:0] {IDLE, REQ, STRB, CONFIG} state_t;
  state_t state, state_nx;
  logic [PW-1:0] pcnt;
  logic [SW-1:0] scnt;
  logic [TW-1:0] tcnt;
  logic tick, t_exp;
  assign clk_en_o = pcnt == P_LAST;
  assign tick = clk_en_o && scnt == S_LAST;
  assign t_exp = clk_en_o && tcnt == T_LAST;
  assign adc_req_o = state == REQ;
  assign dataVaild_STRB_o = state == STRB;
  assign config_en_o = state == CONFIG;
  assign state_o = state;
  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    state_nx = config_en_i ? CONFIG : tick ? REQ : IDLE;
      REQ:     state_nx = adc_ack_i ? STRB : t_exp ? IDLE : REQ;
      STRB:    state_nx = clk_en_o ? IDLE : STRB;
      default: state_nx = config_en_i ? CONFIG : IDLE;
    endcase
  end
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      state <= IDLE;
      pcnt <= '0;
      scnt <= '0;
      tcnt <= '0;
      ADC_value_o <= '0;
      SET_value_o <= '0;
      timeout_o <= 1'b0;
    end else if (!enable_i) begin
      state <= IDLE;
      pcnt <= '0;
      scnt <= '0;
      tcnt <= '0;
    end else begin
      state <= state_nx;
      pcnt <= clk_en_o ? '0 : pcnt + 1'b1;
      // leaving config restarts the sample interval from zero
      scnt <= (state == CONFIG && !config_en_i) ? '0 : !clk_en_o ? scnt : scnt == S_LAST ? '0 : scnt + 1'b1;
      tcnt <= state != REQ ? '0 : clk_en_o ? tcnt + 1'b1 : tcnt;
      if (state == REQ && adc_ack_i) begin
        ADC_value_o <= adc_data_i;
        SET_value_o <= set_value_i;
      end
      timeout_o <= (state == IDLE && config_en_i) ? 1'b0 : (state == REQ && !adc_ack_i && t_exp) ? 1'b1 : timeout_o;
    end
  end
endmodule

// File: tb/tb_fan_sample_sequencer.sv
// tb_fan_sample_sequencer: scoreboard bench for the fan sample sequencer
module tb_fan_sample_sequencer;
  logic clk, rstn, enable, config_en, ack;
  logic [3:0] adc_data, set_value;
  logic req, clk_en, strb, cfg, tmo;
  logic [3:0] adc_val, set_val;
  logic [1:0] state;
  typedef struct {int cyc; logic [13:0] obs;} ev_t;
  ev_t evq[$];
  int ceq[$];
  ev_t e;
  int cyc = 0, total = 0, fails = 0, base = 0, ce_exp = 0;
  logic watch_ce = 1'b0;
  logic [13:0] prev = '0, o;
  fan_sample_sequencer #(.ADC_BITWIDTH(4), .PRESCALE(10), .SAMPLE_DIV(4), .ACK_TIMEOUT(8)) dut (
    .clk_i(clk), .rstn_i(rstn), .enable_i(enable), .config_en_i(config_en),
    .adc_data_i(adc_data), .set_value_i(set_value), .adc_ack_i(ack),
    .adc_req_o(req), .clk_en_o(clk_en), .ADC_value_o(adc_val), .SET_value_o(set_val),
    .dataVaild_STRB_o(strb), .config_en_o(cfg), .timeout_o(tmo), .state_o(state)
  );
  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  always @(negedge clk) begin
    o = {req, strb, cfg, tmo, state, adc_val, set_val};
    if (o !== prev) begin
      total++;
      if (evq.size() == 0) begin
        fails++;
        $display("FAIL event: unexpected change at cyc %0d obs %h, required no change", cyc - base, o);
      end else begin
        e = evq.pop_front();
        if (e.cyc != cyc || e.obs !== o) begin
          fails++;
          $display("FAIL event: got cyc %0d obs %h, required cyc %0d obs %h", cyc - base, o, e.cyc - base, e.obs);
        end
      end
    end
    prev = o;
    if (watch_ce && clk_en) begin
      total++;
      if (ceq.size() == 0) begin
        fails++;
        $display("FAIL clk_en: unexpected pulse at cyc %0d", cyc - base);
      end else begin
        ce_exp = ceq.pop_front();
        if (ce_exp != cyc) begin
          fails++;
          $display("FAIL clk_en: got pulse at cyc %0d, required %0d", cyc - base, ce_exp - base);
        end
      end
    end
  end
  task automatic ev(input int c, input logic rq, sb, cf, tm, input logic [1:0] st, input logic [3:0] a, s);
    evq.push_back('{base + c, {rq, sb, cf, tm, st, a, s}});
  endtask
  task automatic wait_cyc(input int c);
    while (cyc < base + c) @(negedge clk);
  endtask
  task automatic chk(input string n, input logic [31:0] got, exp);
    total++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %h, required %h", n, got, exp);
    end
  endtask
  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end
  initial begin
    rstn = 1'b0; enable = 1'b0; config_en = 1'b0; ack = 1'b0; adc_data = '0; set_value = '0;
    repeat (3) @(negedge clk);
    chk("reset_outputs", {18'd0, req, clk_en, strb, cfg, tmo, state, adc_val, set_val}, 32'd0);
    rstn = 1'b1; enable = 1'b1; base = cyc;
    for (int i = 0; i < 4; i++) ceq.push_back(base + 9 + 10 * i);
    ev(40, 1, 0, 0, 0, 1, 4'h0, 4'h0);
    ev(43, 0, 1, 0, 0, 2, 4'hA, 4'h5);
    ev(50, 0, 0, 0, 0, 0, 4'hA, 4'h5);
    ev(80, 1, 0, 0, 0, 1, 4'hA, 4'h5);
    ev(160, 0, 0, 0, 1, 0, 4'hA, 4'h5);
    ev(200, 1, 0, 0, 1, 1, 4'hA, 4'h5);
    ev(204, 0, 1, 0, 1, 2, 4'h3, 4'hC);
    ev(210, 0, 0, 0, 1, 0, 4'h3, 4'hC);
    ev(211, 0, 0, 1, 0, 3, 4'h3, 4'hC);
    ev(216, 0, 0, 0, 0, 0, 4'h3, 4'hC);
    ev(250, 1, 0, 0, 0, 1, 4'h3, 4'hC);
    ev(252, 0, 1, 0, 0, 2, 4'h7, 4'h9);
    ev(255, 0, 0, 0, 0, 0, 4'h7, 4'h9);
    ev(310, 1, 0, 0, 0, 1, 4'h7, 4'h9);
    ev(313, 0, 0, 0, 0, 0, 4'h0, 4'h0);
    watch_ce = 1'b1;
    wait_cyc(42);
    ack = 1'b1; adc_data = 4'hA; set_value = 4'h5;
    wait_cyc(43);
    ack = 1'b0; adc_data = 4'hF; set_value = 4'hF;
    wait_cyc(45);
    watch_ce = 1'b0;
    wait_cyc(201);
    config_en = 1'b1;
    wait_cyc(203);
    ack = 1'b1; adc_data = 4'h3; set_value = 4'hC;
    wait_cyc(204);
    ack = 1'b0; adc_data = 4'hE; set_value = 4'h1;
    wait_cyc(215);
    config_en = 1'b0;
    wait_cyc(251);
    ack = 1'b1; adc_data = 4'h7; set_value = 4'h9;
    wait_cyc(252);
    ack = 1'b0;
    wait_cyc(254);
    enable = 1'b0;
    ceq.push_back(base + 279);
    wait_cyc(255);
    watch_ce = 1'b1;
    wait_cyc(270);
    enable = 1'b1;
    wait_cyc(285);
    watch_ce = 1'b0;
    wait_cyc(312);
    #2 rstn = 1'b0;
    #1 chk("async_reset", {18'd0, req, clk_en, strb, cfg, tmo, state, adc_val, set_val}, 32'd0);
    #1 rstn = 1'b1;
    wait_cyc(320);
    chk("events_pending", evq.size(), 0);
    chk("clk_en_pending", ceq.size(), 0);
    $display("%0d/%0d checks passed", total - fails, total);
    $finish;
  end
endmodule
